// File: rtl/datapath_pkg.sv
// Shared datapath definitions: bus geometry, register index map and the
// transfer FSM state type used by the bus transfer unit.
package datapath_pkg;

    localparam int IDX_W      = 5;
    localparam int DATA_WIDTH = 32;

    // Source/destination indices; destination i is the same register as source i.
    localparam logic [IDX_W-1:0] R0     = 5'd0;
    localparam logic [IDX_W-1:0] R1     = 5'd1;
    localparam logic [IDX_W-1:0] R2     = 5'd2;
    localparam logic [IDX_W-1:0] R3     = 5'd3;
    localparam logic [IDX_W-1:0] R4     = 5'd4;
    localparam logic [IDX_W-1:0] R5     = 5'd5;
    localparam logic [IDX_W-1:0] R6     = 5'd6;
    localparam logic [IDX_W-1:0] R7     = 5'd7;
    localparam logic [IDX_W-1:0] R8     = 5'd8;
    localparam logic [IDX_W-1:0] R9     = 5'd9;
    localparam logic [IDX_W-1:0] R10    = 5'd10;
    localparam logic [IDX_W-1:0] R11    = 5'd11;
    localparam logic [IDX_W-1:0] R12    = 5'd12;
    localparam logic [IDX_W-1:0] R13    = 5'd13;
    localparam logic [IDX_W-1:0] R14    = 5'd14;
    localparam logic [IDX_W-1:0] R15    = 5'd15;
    localparam logic [IDX_W-1:0] HI     = 5'd16;
    localparam logic [IDX_W-1:0] LO     = 5'd17;
    localparam logic [IDX_W-1:0] ZHI    = 5'd18;
    localparam logic [IDX_W-1:0] ZLO    = 5'd19;
    localparam logic [IDX_W-1:0] PC     = 5'd20;
    localparam logic [IDX_W-1:0] MDR    = 5'd21;
    localparam logic [IDX_W-1:0] INPORT = 5'd22;
    localparam logic [IDX_W-1:0] CSIGN  = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ERR   = 2'd2
    } xfer_state_t;

endpackage

// File: rtl/bus_src_mux.sv
// Combinational NUM_SRC:1 bus source selector. The caller guarantees the
// index is in range; an out-of-range index simply yields zero.
module bus_src_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 24,
    parameter int IDX_W      = 5
) (
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    input  logic [IDX_W-1:0]              sel_i,
    output logic [DATA_WIDTH-1:0]         data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_i == IDX_W'(i)) begin
                data_o = src_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/bus_transfer_unit.sv
// Register-transfer engine: latches one source onto BusMuxOut and pulses a
// single destination enable, with write-to-read forwarding for back-to-back moves.
module bus_transfer_unit #(
    parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
    parameter int NUM_SRC    = 24,
    parameter int NUM_DST    = 20,
    parameter int IDX_W      = datapath_pkg::IDX_W
) (
    input  logic                          clock,
    input  logic                          clear_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [IDX_W-1:0]              req_src,
    input  logic [IDX_W-1:0]              req_dst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0]         BusMuxOut,
    output logic [NUM_DST-1:0]            dst_enable,
    output logic                          done,
    output logic                          error
);

    import datapath_pkg::*;

    localparam logic [IDX_W:0] SRC_LIMIT = (IDX_W+1)'(NUM_SRC);
    localparam logic [IDX_W:0] DST_LIMIT = (IDX_W+1)'(NUM_DST);

    xfer_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] busOut_q, busOut_d;
    logic [IDX_W-1:0]      dst_q, dst_d;
    logic [DATA_WIDTH-1:0] muxData;
    logic                  accept;
    logic                  idxValid;
    logic                  forward;

    bus_src_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_SRC   (NUM_SRC),
        .IDX_W     (IDX_W)
    ) u_src_mux (
        .src_data_i(src_data),
        .sel_i     (req_src),
        .data_o    (muxData)
    );

    assign req_ready = clear_n;
    assign accept    = req_valid && req_ready;
    assign idxValid  = ({1'b0, req_src} < SRC_LIMIT) && ({1'b0, req_dst} < DST_LIMIT);

    // The register being written this cycle still shows its old BusMuxIn,
    // so a read of it must take the value currently on the bus.
    assign forward = (state_q == WRITE) && (req_src == dst_q);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            busOut_q <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            busOut_q <= busOut_d;
            dst_q    <= dst_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        busOut_d = busOut_q;
        dst_d    = dst_q;
        if (accept) begin
            if (idxValid) begin
                state_d  = WRITE;
                dst_d    = req_dst;
                busOut_d = forward ? busOut_q : muxData;
            end else begin
                state_d = ERR;
            end
        end
    end

    always_comb begin
        dst_enable = '0;
        for (int i = 0; i < NUM_DST; i++) begin
            dst_enable[i] = (state_q == WRITE) && (dst_q == IDX_W'(i));
        end
    end

    assign BusMuxOut = busOut_q;
    assign done      = (state_q == WRITE);
    assign error     = (state_q == ERR);

endmodule

// File: tb/tb_bus_transfer_unit.sv
// Scoreboard bench for bus_transfer_unit: directed requests push expected
// bus responses; a negedge monitor pops them whenever done or error shows.
module tb_bus_transfer_unit;

    localparam int DW      = 32;
    localparam int NSRC    = 24;
    localparam int NDST    = 20;
    localparam int IW      = 5;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] bus;
        logic [31:0] en;
    } exp_t;

    localparam logic [1:0] KIND_WRITE = 2'b10;
    localparam logic [1:0] KIND_ERR   = 2'b01;

    logic                 clock = 1'b0;
    logic                 clear_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [IW-1:0]        req_src;
    logic [IW-1:0]        req_dst;
    logic [NSRC*DW-1:0]   src_data;
    logic [DW-1:0]        BusMuxOut;
    logic [NDST-1:0]      dst_enable;
    logic                 done;
    logic                 error;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   testsFail = 0;
    logic monitorOn = 1'b0;

    bus_transfer_unit #(
        .DATA_WIDTH(DW),
        .NUM_SRC   (NSRC),
        .NUM_DST   (NDST),
        .IDX_W     (IW)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .src_data  (src_data),
        .BusMuxOut (BusMuxOut),
        .dst_enable(dst_enable),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic setSrc(input int idx, input logic [31:0] val);
        src_data[idx*DW +: DW] = val;
    endtask

    // Present one request for exactly one clock edge and record its expected response.
    task automatic applyStimulus(input logic [IW-1:0] src, input logic [IW-1:0] dst,
                                 input logic [1:0] kind, input logic [31:0] bus, input logic [31:0] en);
        exp_t e;
        e.kind = kind;
        e.bus  = bus;
        e.en   = en;
        expQ.push_back(e);
        req_valid = 1'b1;
        req_src   = src;
        req_dst   = dst;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    always @(negedge clock) begin
        if (monitorOn && clear_n) begin
            if (done || error) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected response", {30'd0, done, error}, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("response kind {done,error}", {30'd0, done, error}, {30'd0, e.kind});
                    checkOutput("BusMuxOut", BusMuxOut, e.bus);
                    checkOutput("dst_enable", {12'd0, dst_enable}, e.en);
                end
            end else begin
                checkOutput("idle dst_enable", {12'd0, dst_enable}, 32'd0);
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        src_data  = '0;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset BusMuxOut", BusMuxOut, 32'd0);
        checkOutput("reset dst_enable", {12'd0, dst_enable}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset error", {31'd0, error}, 32'd0);
        clear_n   = 1'b1;
        monitorOn = 1'b1;
        #1;
        checkOutput("req_ready after reset", {31'd0, req_ready}, 32'd1);

        // Single transfer, then back to IDLE.
        setSrc(3, 32'hDEADBEEF);
        applyStimulus(5'd3, 5'd7, KIND_WRITE, 32'hDEADBEEF, 32'h0000_0080);
        idleCycles(2);
        checkOutput("BusMuxOut held in IDLE", BusMuxOut, 32'hDEADBEEF);

        // Back-to-back transfers without a bubble.
        setSrc(1, 32'h0101_0101);
        setSrc(4, 32'h0404_0404);
        applyStimulus(5'd1, 5'd2, KIND_WRITE, 32'h0101_0101, 32'h0000_0004);
        applyStimulus(5'd4, 5'd5, KIND_WRITE, 32'h0404_0404, 32'h0000_0020);
        idleCycles(1);

        // Forwarding: register 6 is being written while it is read.
        setSrc(0, 32'h1111_1111);
        setSrc(6, 32'h0000_0000);
        applyStimulus(5'd0, 5'd6, KIND_WRITE, 32'h1111_1111, 32'h0000_0040);
        applyStimulus(5'd6, 5'd9, KIND_WRITE, 32'h1111_1111, 32'h0000_0200);
        idleCycles(1);

        // src == dst reloads the register's own value.
        applyStimulus(5'd4, 5'd4, KIND_WRITE, 32'h0404_0404, 32'h0000_0010);
        idleCycles(1);

        // Invalid indices leave the bus and destinations untouched.
        setSrc(8, 32'hA5A5_A5A5);
        applyStimulus(5'd8, 5'd1, KIND_WRITE, 32'hA5A5_A5A5, 32'h0000_0002);
        applyStimulus(5'd30, 5'd2, KIND_ERR, 32'hA5A5_A5A5, 32'h0);
        idleCycles(1);
        applyStimulus(5'd1, 5'd21, KIND_ERR, 32'hA5A5_A5A5, 32'h0);
        idleCycles(1);
        checkOutput("BusMuxOut after errors", BusMuxOut, 32'hA5A5_A5A5);

        // Source data changes right after the accept edge.
        setSrc(5, 32'h55AA_55AA);
        applyStimulus(5'd5, 5'd10, KIND_WRITE, 32'h55AA_55AA, 32'h0000_0400);
        setSrc(5, 32'h1234_5678);
        idleCycles(1);

        // Reset in the middle of a WRITE cycle.
        setSrc(2, 32'h2222_2222);
        applyStimulus(5'd2, 5'd3, KIND_WRITE, 32'h2222_2222, 32'h0000_0008);
        @(negedge clock);
        #1;
        clear_n = 1'b0;
        #1;
        checkOutput("mid-WRITE reset dst_enable", {12'd0, dst_enable}, 32'd0);
        checkOutput("mid-WRITE reset done", {31'd0, done}, 32'd0);
        checkOutput("mid-WRITE reset BusMuxOut", BusMuxOut, 32'd0);
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        #1;
        checkOutput("post-reset done", {31'd0, done}, 32'd0);
        checkOutput("post-reset error", {31'd0, error}, 32'd0);
        checkOutput("post-reset dst_enable", {12'd0, dst_enable}, 32'd0);
        idleCycles(2);

        // Normal operation resumes.
        applyStimulus(5'd2, 5'd19, KIND_WRITE, 32'h2222_2222, 32'h0008_0000);
        idleCycles(3);

        checkOutput("pending expectations", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule

// File: doc/bus_transfer_unit.md
# bus_transfer_unit

Bus-side counterpart of the datapath register file. Each register drives its `BusMuxIn` output toward the bus and loads from `BusMuxOut` when its enable is high. This block is the other end of that interface: it accepts register-transfer requests, selects one source's `BusMuxIn` onto a registered `BusMuxOut`, and pulses exactly one destination enable. It sits between the control unit and the register bank, and supports back-to-back transfers with write-to-read forwarding.

## Interface

Parameters:
- `DATA_WIDTH`, 32, bus width.
- `NUM_SRC`, 24, number of bus sources; indices 0..NUM_SRC-1.
- `NUM_DST`, 20, number of loadable destinations; destination index i is the same register as source index i.
- `IDX_W`, 5, width of the source and destination index fields; must satisfy 2^IDX_W >= NUM_SRC.

Ports:
- `clock` in 1: single clock, rising edge.
- `clear_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: transfer request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_src` in IDX_W: source index.
- `req_dst` in IDX_W: destination index.
- `src_data` in NUM_SRC*DATA_WIDTH: concatenated `BusMuxIn` of all sources; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `BusMuxOut` out DATA_WIDTH: registered bus value.
- `dst_enable` out NUM_DST: one-hot destination load enable.
- `done` out 1: a transfer's write cycle is in progress.
- `error` out 1: a rejected request is being reported.

## Operation

- Accept condition: `req_valid && req_ready`, sampled on a rising edge.
- FSM states:
  - IDLE: `req_ready`=1, `dst_enable`=0.
  - WRITE: `req_ready`=1, `dst_enable[dst_q]`=1, `done`=1.
  - ERR: `req_ready`=1, `error`=1, `dst_enable`=0.
- Transitions:
  - Valid accept from any state → WRITE.
  - Invalid accept (`req_src`>=NUM_SRC or `req_dst`>=NUM_DST) → ERR.
  - No accept → IDLE.
- On a valid accept:
  - `BusMuxOut` <= selected source data.
  - `dst_q` <= `req_dst`.
- Forwarding: if the accept happens in WRITE and `req_src` == `dst_q`, capture the current `BusMuxOut` instead of `src_data`. At that same edge the destination register is loading `BusMuxOut`, so its `BusMuxIn` is still stale.
- Invalid accept: `BusMuxOut` and `dst_q` are unchanged, and no destination is written.
- `BusMuxOut` holds its last value in IDLE and ERR.
- `dst_enable` is always zero or exactly one-hot. It is decoded from registered state only.

## Timing

- Reset values (asynchronous, while `clear_n`=0): state IDLE, `BusMuxOut`=0, `dst_q`=0, `dst_enable`=0, `done`=0, `error`=0.
- `req_ready` is 1 whenever `clear_n`=1.
- Latency: request accepted at edge k.
  - `BusMuxOut` is valid and `dst_enable` is high for the cycle between edges k and k+1.
  - The destination register loads at edge k+1.
- Throughput: one transfer per cycle, with no bubble between consecutive requests.
- `src_data` is sampled only at the accept edge. Later changes do not affect an in-flight transfer.
- Reset asserted mid-WRITE:
  - `dst_enable` drops to 0 immediately (asynchronously).
  - The transfer is lost; no done or error is reported afterwards.
- src == dst in the same request is legal: the register reloads its own value.
- The forwarding check compares indices only. A WRITE followed by an ERR does not disturb `BusMuxOut`.

## Structure

- Shared package `datapath_pkg`:
  - `IDX_W`, `DATA_WIDTH`.
  - Register index constants (R0..R15, HI, LO, ZHI, ZLO, PC, MDR, INPORT, CSIGN).
  - FSM state enum `xfer_state_t` (IDLE, WRITE, ERR).
- One sub-module, `bus_src_mux`: combinational NUM_SRC:1 selector from `src_data` by index. The index is range-checked by the parent.
- All state lives in the parent: FSM, `BusMuxOut`, `dst_q`.

## Test plan

- Reset, then a single transfer. Stimulus: hold `clear_n`=0, release, set source 3 = 0xDEADBEEF, request src=3 dst=7. Required: `BusMuxOut`=0 during reset; the next cycle shows `BusMuxOut`=0xDEADBEEF, `dst_enable`=1<<7, `done`=1; the cycle after returns to IDLE with all enables 0.
- Back-to-back transfers. Stimulus: src=1→dst=2, then src=4→dst=5 on consecutive cycles. Required: two consecutive WRITE cycles; `dst_enable` goes 0x4 then 0x20 with no gap; `BusMuxOut` follows source values.
- Forwarding. Stimulus: src=0 (0x11111111)→dst=6, then next cycle src=6→dst=9 while `src_data[6]` still shows the stale value 0x0. Required: the second transfer drives 0x11111111 and `dst_enable`=1<<9.
- Invalid index. Stimulus: src=30, dst=2 after a prior transfer left `BusMuxOut`=0xA5A5A5A5. Required: one cycle with `error`=1 and `dst_enable`=0; `BusMuxOut` stays 0xA5A5A5A5. Repeat with dst=21 for the same response.
- Reset mid-WRITE. Stimulus: accept src=2→dst=3, then pull `clear_n` low halfway through the WRITE cycle. Required: `dst_enable` and `done` go to 0 immediately; `BusMuxOut`=0; state is IDLE after release.
- Source change after accept. Stimulus: request src=5 at edge k, then change `src_data[5]` right after edge k. Required: `BusMuxOut` holds the value sampled at edge k.
